// File: rtl/data_bus_arbiter_pkg.sv
// rtl/data_bus_arbiter_pkg.sv - shared types and constants for the data bus arbiter
//
// Purpose : arbiter FSM state encoding, master ids and the device codes
//           that the bus address decoder also uses (address bits 15:12).
// Ports   : none (package).
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

   localparam logic [3:0] DEV_MEM = 4'h0;
   localparam logic [3:0] DEV_FP  = 4'h1;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// rtl/data_bus_arbiter_if.sv - Avalon-style two-master data bus bundle
//
// Purpose : groups both master ports and the shared bus port.
// Ports   : M0_*/M1_*  master request strobes, address, write data,
//                      read data and Waitreq stall
//           Bus*       strobes, address and write data towards the devices,
//                      read data and Waitreq back from them
// Modports: slave  - arbiter view (takes master requests, drives the bus)
//           master - environment view (drives requests, models the bus)
interface data_bus_arbiter_if;

   logic        M0_Read;
   logic        M0_Write;
   logic [15:0] M0_Addr;
   logic [15:0] M0_WrData;
   logic [15:0] M0_RdData;
   logic        M0_Waitreq;

   logic        M1_Read;
   logic        M1_Write;
   logic [15:0] M1_Addr;
   logic [15:0] M1_WrData;
   logic [15:0] M1_RdData;
   logic        M1_Waitreq;

   logic        BusRead;
   logic        BusWrite;
   logic [15:0] BusAddr;
   logic [15:0] BusIn;
   logic [15:0] BusOut;
   logic        BusWaitreq;

   modport slave (
      input  M0_Read, M0_Write, M0_Addr, M0_WrData,
      output M0_RdData, M0_Waitreq,
      input  M1_Read, M1_Write, M1_Addr, M1_WrData,
      output M1_RdData, M1_Waitreq,
      output BusRead, BusWrite, BusAddr, BusIn,
      input  BusOut, BusWaitreq
   );

   modport master (
      output M0_Read, M0_Write, M0_Addr, M0_WrData,
      input  M0_RdData, M0_Waitreq,
      output M1_Read, M1_Write, M1_Addr, M1_WrData,
      input  M1_RdData, M1_Waitreq,
      input  BusRead, BusWrite, BusAddr, BusIn,
      output BusOut, BusWaitreq
   );

endinterface

// File: rtl/data_bus_arbiter_rr_pick2.sv
// rtl/data_bus_arbiter_rr_pick2.sv - two-way round-robin winner selection
//
// Purpose : combinational pick between two requesters; on a tie the master
//           that was not served last wins.
// Ports   : req0, req1   request from master 0 / master 1
//           last_served  id of the master that completed most recently
//           valid        at least one request present
//           winner       id of the selected master (meaningful when valid)
module rr_pick2
   import bus_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_served,
   output logic valid,
   output logic winner
);

   assign valid  = req0 | req1;
   assign winner = (req0 & req1) ? ((last_served == M_CPU) ? M_AUX : M_CPU)
                                 : (req1 ? M_AUX : M_CPU);

endmodule

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - round-robin arbiter for the shared data bus
//
// Purpose : shares one Avalon-style data bus between the CPU data port
//           (master 0) and a secondary requester (master 1). The grant is
//           registered and held until the bus drops Waitreq; a watchdog
//           aborts a granted transaction stalled for TIMEOUT cycles.
// Ports   : Clock    system clock
//           Reset    synchronous, active-high reset
//           bus      data_bus_arbiter_if.slave (both masters + bus side)
//           Timeout  sticky flag, set by a watchdog abort until Reset
module data_bus_arbiter
   import bus_pkg::*;
#(
   parameter int          TIMEOUT    = 64,
   parameter logic [15:0] ABORT_DATA = 16'hDEAD
)(
   input  logic                 Clock,
   input  logic                 Reset,
   data_bus_arbiter_if.slave    bus,
   output logic                 Timeout
);

   // wait_cnt never has to hold more than TIMEOUT-1.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

   logic            req0, req1;
   logic            pick_valid, pick_winner;
   logic            gid;
   logic            g_req, g_read, g_write, o_req;
   logic [15:0]     g_addr, g_wrdata;
   logic            abort, complete;
   logic [15:0]     g_rddata;
   logic            g_waitreq;

   assign req0 = bus.M0_Read | bus.M0_Write;
   assign req1 = bus.M1_Read | bus.M1_Write;

   rr_pick2 u_pick (
      .req0        (req0),
      .req1        (req1),
      .last_served (last_q),
      .valid       (pick_valid),
      .winner      (pick_winner)
   );

   // Granted-master view; only meaningful while in a GRANT state.
   assign gid      = (state_q == GRANT1) ? M_AUX : M_CPU;
   assign g_read   = (gid == M_AUX) ? bus.M1_Read   : bus.M0_Read;
   assign g_write  = (gid == M_AUX) ? bus.M1_Write  : bus.M0_Write;
   assign g_addr   = (gid == M_AUX) ? bus.M1_Addr   : bus.M0_Addr;
   assign g_wrdata = (gid == M_AUX) ? bus.M1_WrData : bus.M0_WrData;
   assign g_req    = g_read | g_write;
   assign o_req    = (gid == M_AUX) ? req0 : req1;

   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      wait_cnt_d     = wait_cnt_q;
      abort          = 1'b0;
      complete       = 1'b0;
      g_rddata       = '0;
      g_waitreq      = 1'b1;
      bus.BusRead    = 1'b0;
      bus.BusWrite   = 1'b0;
      bus.BusAddr    = '0;
      bus.BusIn      = '0;
      bus.M0_RdData  = '0;
      bus.M0_Waitreq = 1'b1;
      bus.M1_RdData  = '0;
      bus.M1_Waitreq = 1'b1;

      case (state_q)
         IDLE: begin
            // Strobes stay low here, so there is no request-to-strobe path.
            if (pick_valid) begin
               state_d    = (pick_winner == M_AUX) ? GRANT1 : GRANT0;
               wait_cnt_d = '0;
            end
         end

         GRANT0, GRANT1: begin
            abort    = (TIMEOUT != 0) && g_req && bus.BusWaitreq &&
                       (wait_cnt_q == CW'(TIMEOUT - 1));
            complete = g_req && (!bus.BusWaitreq || abort);

            // Pass-through of the granted master; Write wins over Read and an
            // abort pulls both strobes so the device never sees the access.
            bus.BusWrite = g_write & ~abort;
            bus.BusRead  = g_read & ~g_write & ~abort;
            bus.BusAddr  = g_addr;
            bus.BusIn    = g_wrdata;

            g_rddata  = abort ? ABORT_DATA : bus.BusOut;
            g_waitreq = bus.BusWaitreq & ~abort;
            if (gid == M_AUX) begin
               bus.M1_RdData  = g_rddata;
               bus.M1_Waitreq = g_waitreq;
            end else begin
               bus.M0_RdData  = g_rddata;
               bus.M0_Waitreq = g_waitreq;
            end

            if (!g_req) begin
               // Master walked away mid-transaction: release without
               // crediting it as served.
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else if (complete) begin
               last_d     = gid;
               wait_cnt_d = '0;
               if (o_req) begin
                  state_d = (gid == M_AUX) ? GRANT0 : GRANT1;
               end
            end else begin
               // Not complete with a live request means BusWaitreq is high.
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         last_q     <= M_AUX;
         wait_cnt_q <= '0;
         Timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         wait_cnt_q <= wait_cnt_d;
         Timeout    <= Timeout | abort;
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;
   import bus_pkg::*;

   localparam int TO = 8;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   logic Timeout;

   data_bus_arbiter_if bus_if ();

   data_bus_arbiter #(.TIMEOUT(TO), .ABORT_DATA(16'hDEAD)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .bus     (bus_if.slave),
      .Timeout (Timeout)
   );

   always #5 Clock = ~Clock;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];

   function automatic logic [15:0] model_rd(input logic [15:0] a);
      return (a == 16'h0010) ? 16'h1234 : ~a;
   endfunction

   function automatic logic [15:0] addr_of(input logic [15:0] base, input int k);
      return base + 16'(2 * k);
   endfunction

   function automatic logic [15:0] data_of(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   always_comb bus_if.BusOut = model_rd(bus_if.BusAddr);

   // Scoreboard: every accepted bus access must match the next expectation.
   always @(negedge Clock) begin : monitor
      exp_t e;
      if (!Reset && (bus_if.BusRead || bus_if.BusWrite) && !bus_if.BusWaitreq) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected addr=%h wr=%b", bus_if.BusAddr, bus_if.BusWrite);
         end else begin
            e = sb.pop_front();
            if (bus_if.BusAddr !== e.addr || bus_if.BusWrite !== e.wr ||
                bus_if.BusRead !== ~e.wr || (e.wr && bus_if.BusIn !== e.data)) begin
               failures++;
               $display("FAIL sb_access got addr=%h wr=%b rd=%b din=%h want addr=%h wr=%b din=%h",
                        bus_if.BusAddr, bus_if.BusWrite, bus_if.BusRead, bus_if.BusIn,
                        e.addr, e.wr, e.data);
            end
         end
      end
   end

   task automatic push_exp(input logic [15:0] a, input logic wr);
      exp_t e;
      e.addr = a;
      e.wr   = wr;
      e.data = data_of(a);
      sb.push_back(e);
   endtask

   task automatic set_req(input int id, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d);
      if (id == 0) begin
         bus_if.M0_Read = rd; bus_if.M0_Write = wr;
         bus_if.M0_Addr = a;  bus_if.M0_WrData = d;
      end else begin
         bus_if.M1_Read = rd; bus_if.M1_Write = wr;
         bus_if.M1_Addr = a;  bus_if.M1_WrData = d;
      end
   endtask

   // Avalon master: holds each request until it sees Waitreq low, then
   // issues the next one (or drops) right after the following edge.
   task automatic master_seq(input int id, input int n, input logic [15:0] base,
                             input logic wr, input logic abort, output int waits);
      logic [15:0] a;
      logic [15:0] rd;
      logic [15:0] exp_rd;
      logic        wq;
      int          cnt;
      waits = 0;
      for (int k = 0; k < n; k++) begin
         a = addr_of(base, k);
         set_req(id, ~wr, wr, a, data_of(a));
         cnt = 0;
         while (cnt < 64) begin
            @(negedge Clock);
            wq = (id == 0) ? bus_if.M0_Waitreq : bus_if.M1_Waitreq;
            if (!wq) break;
            cnt++;
         end
         if (k == 0) waits = cnt;
         if (cnt >= 64) begin
            checks++;
            failures++;
            $display("FAIL m%0d_wait_bound addr=%h still stalled after %0d cycles", id, a, cnt);
         end else if (!wr) begin
            rd     = (id == 0) ? bus_if.M0_RdData : bus_if.M1_RdData;
            exp_rd = abort ? 16'hDEAD : model_rd(a);
            checks++;
            if (rd !== exp_rd) begin
               failures++;
               $display("FAIL m%0d_rddata addr=%h got=%h want=%h", id, a, rd, exp_rd);
            end
         end
         @(posedge Clock); #1;
      end
      set_req(id, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic gap();
      repeat (3) @(posedge Clock);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge Clock); #1 Reset = 1'b1;
      @(posedge Clock); #1 Reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge Clock);
      #1 bus_if.M0_Read = 1'b1;
      @(negedge Clock);
      checks++;
      if ({bus_if.BusRead, bus_if.BusWrite, Timeout, bus_if.M0_Waitreq, dut.state_q == IDLE} !== 5'b00011) begin
         failures++;
         $display("FAIL reset_ctrl got rd=%b wr=%b to=%b m0wq=%b st=%0d want 0 0 0 1 IDLE",
                  bus_if.BusRead, bus_if.BusWrite, Timeout, bus_if.M0_Waitreq, dut.state_q);
      end
      checks++;
      if ({bus_if.M0_RdData, bus_if.M1_RdData} !== 32'h0) begin
         failures++;
         $display("FAIL reset_rddata got m0=%h m1=%h want 0 0", bus_if.M0_RdData, bus_if.M1_RdData);
      end
      @(posedge Clock); #1;
      bus_if.M0_Read = 1'b0;
      Reset          = 1'b0;
   endtask

   task automatic test_single();
      int w;
      push_exp(16'h0010, 1'b0);
      master_seq(0, 1, 16'h0010, 1'b0, 1'b0, w);
      checks++;
      if (w != 1) begin
         failures++;
         $display("FAIL single_latency got=%0d want=1", w);
      end
      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL single_idle got=%0d want=%0d", dut.state_q, IDLE);
      end
   endtask

   task automatic test_contention();
      int w0, w1;
      apply_reset();
      push_exp(16'h0040, 1'b1);
      push_exp(16'h0100, 1'b1);
      fork
         master_seq(0, 1, 16'h0040, 1'b1, 1'b0, w0);
         master_seq(1, 1, 16'h0100, 1'b1, 1'b0, w1);
         begin
            @(negedge Clock);
            checks++;
            if (bus_if.BusWrite !== 1'b0) begin
               failures++;
               $display("FAIL cont_idle BusWrite got=%b want=0", bus_if.BusWrite);
            end
            @(negedge Clock);
            checks++;
            if (bus_if.BusAddr !== 16'h0040 || bus_if.BusWrite !== 1'b1) begin
               failures++;
               $display("FAIL cont_first got addr=%h wr=%b want 0040 1", bus_if.BusAddr, bus_if.BusWrite);
            end
            @(negedge Clock);
            checks++;
            if (bus_if.BusAddr !== 16'h0100 || bus_if.BusWrite !== 1'b1) begin
               failures++;
               $display("FAIL cont_second got addr=%h wr=%b want 0100 1", bus_if.BusAddr, bus_if.BusWrite);
            end
         end
      join
      checks++;
      if (w0 != 1 || w1 != 2) begin
         failures++;
         $display("FAIL cont_waits got m0=%0d m1=%0d want 1 2", w0, w1);
      end
   endtask

   task automatic test_fairness();
      int w0, w1;
      gap();
      for (int k = 0; k < 3; k++) begin
         push_exp(addr_of(16'h0200, k), 1'b0);
         push_exp(addr_of(16'h1200, k), 1'b1);
      end
      fork
         master_seq(0, 3, 16'h0200, 1'b0, 1'b0, w0);
         master_seq(1, 3, 16'h1200, 1'b1, 1'b0, w1);
      join
   endtask

   task automatic test_fp_stall();
      int w0, w1, n;
      gap();
      bus_if.BusWaitreq = 1'b1;
      push_exp(16'h1002, 1'b1);
      push_exp(16'h0020, 1'b0);
      fork
         master_seq(1, 1, 16'h1002, 1'b1, 1'b0, w1);
         begin
            @(posedge Clock); #1;
            master_seq(0, 1, 16'h0020, 1'b0, 1'b0, w0);
         end
         begin
            n = 0;
            do begin
               @(negedge Clock);
               n++;
            end while (!bus_if.BusWrite && n < 10);
            for (int i = 0; i < 6; i++) begin
               if (i > 0) @(negedge Clock);
               checks++;
               if ({bus_if.M1_Waitreq, bus_if.M0_Waitreq} !== {(i < 5), 1'b1}) begin
                  failures++;
                  $display("FAIL stall_wq cycle=%0d got m1=%b m0=%b want m1=%b m0=1",
                           i, bus_if.M1_Waitreq, bus_if.M0_Waitreq, (i < 5));
               end
               if (i == 4) begin
                  @(posedge Clock); #1 bus_if.BusWaitreq = 1'b0;
               end
            end
         end
      join
   endtask

   task automatic test_timeout();
      int w0, n;
      gap();
      checks++;
      if (Timeout !== 1'b0) begin
         failures++;
         $display("FAIL to_pre got=%b want=0", Timeout);
      end
      bus_if.BusWaitreq = 1'b1;
      fork
         master_seq(0, 1, 16'h0030, 1'b0, 1'b1, w0);
         begin
            n = 0;
            do begin
               @(negedge Clock);
               n++;
            end while (bus_if.M0_Waitreq && n < 20);
            checks++;
            if (bus_if.BusRead !== 1'b0 || n >= 20) begin
               failures++;
               $display("FAIL to_strobe got BusRead=%b after %0d cycles want 0", bus_if.BusRead, n);
            end
         end
      join
      checks++;
      if (w0 != TO) begin
         failures++;
         $display("FAIL to_cycles got=%0d want=%0d", w0, TO);
      end
      bus_if.BusWaitreq = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      checks++;
      if (Timeout !== 1'b1) begin
         failures++;
         $display("FAIL to_flag got=%b want=1", Timeout);
      end
   endtask

   task automatic test_reset_mid_grant();
      int w0, w1, n;
      gap();
      checks++;
      if (Timeout !== 1'b1) begin
         failures++;
         $display("FAIL to_sticky got=%b want=1", Timeout);
      end
      bus_if.BusWaitreq = 1'b1;
      set_req(1, 1'b0, 1'b1, 16'h1004, data_of(16'h1004));
      n = 0;
      do begin
         @(negedge Clock);
         n++;
      end while (!bus_if.BusWrite && n < 10);
      @(posedge Clock); #1 Reset = 1'b1;
      @(posedge Clock); #1 Reset = 1'b0;
      @(negedge Clock);
      checks++;
      if ({bus_if.BusRead, bus_if.BusWrite, Timeout, dut.state_q == IDLE} !== 4'b0001) begin
         failures++;
         $display("FAIL rst_mid got rd=%b wr=%b to=%b st=%0d want 0 0 0 IDLE",
                  bus_if.BusRead, bus_if.BusWrite, Timeout, dut.state_q);
      end
      set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
      bus_if.BusWaitreq = 1'b0;
      @(posedge Clock); #1;
      push_exp(16'h0050, 1'b1);
      push_exp(16'h1050, 1'b1);
      fork
         master_seq(0, 1, 16'h0050, 1'b1, 1'b0, w0);
         master_seq(1, 1, 16'h1050, 1'b1, 1'b0, w1);
      join
      checks++;
      if (w0 != 1 || w1 != 2) begin
         failures++;
         $display("FAIL rst_tie got m0=%0d m1=%0d want 1 2", w0, w1);
      end
   endtask

   initial begin
      set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
      bus_if.BusWaitreq = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_fp_stall();
      test_timeout();
      test_reset_mid_grant();
      gap();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
